// File: rtl/node_pkg.sv
// Shared codes for the interconnect node: source/destination encodings,
// arbiter FSM states, slot indices and the position of the destination field.
package node_pkg;

    typedef enum logic [1:0] {
        SRC_NONE  = 2'b00,
        SRC_LEFT  = 2'b01,
        SRC_RIGHT = 2'b10,
        SRC_SELF  = 2'b11
    } src_e;

    typedef enum logic [1:0] {
        DST_CTRL  = 2'b00,
        DST_LEFT  = 2'b01,
        DST_RIGHT = 2'b10,
        DST_SELF  = 2'b11
    } dst_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_WAIT = 2'b01,
        ST_SEND = 2'b10,
        ST_GAP  = 2'b11
    } state_e;

    // Slot / request bit positions
    localparam int IDX_LEFT  = 0;
    localparam int IDX_RIGHT = 1;
    localparam int IDX_SELF  = 2;

    // Destination lives in the top DEST_W bits of every word
    localparam int DEST_W = 2;

endpackage

// File: rtl/rr_arbiter3.sv
// Three-way round-robin arbiter: the requester after the one-hot pointer
// has highest priority, wrapping left -> right -> self.
module rr_arbiter3
    import node_pkg::*;
(
    input  logic [2:0] req,
    input  logic [2:0] ptr,
    output logic [2:0] grant
);

    // Priority scan starting just after the last-served source
    always_comb begin
        grant = 3'b000;
        case (ptr)
            3'b001: begin
                if      (req[IDX_RIGHT]) grant = 3'b010;
                else if (req[IDX_SELF])  grant = 3'b100;
                else if (req[IDX_LEFT])  grant = 3'b001;
            end
            3'b010: begin
                if      (req[IDX_SELF])  grant = 3'b100;
                else if (req[IDX_LEFT])  grant = 3'b001;
                else if (req[IDX_RIGHT]) grant = 3'b010;
            end
            default: begin
                if      (req[IDX_LEFT])  grant = 3'b001;
                else if (req[IDX_RIGHT]) grant = 3'b010;
                else if (req[IDX_SELF])  grant = 3'b100;
            end
        endcase
    end

endmodule

// File: rtl/node_port_arbiter.sv
// Node port arbiter: one-deep holding slots for left/right/self words,
// round-robin grant, destination decode and a single-cycle send pulse
// followed by an optional idle gap.
module node_port_arbiter
    import node_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int GAP_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  resetN,
    input  logic [DATA_WIDTH-1:0] shiftInLeftData,
    input  logic                  shiftInLeftCS,
    input  logic [DATA_WIDTH-1:0] shiftInRightData,
    input  logic                  shiftInRightCS,
    input  logic [DATA_WIDTH-1:0] shiftInData,
    input  logic                  shiftInCS,
    input  logic                  readyLeft,
    input  logic                  readyRight,
    input  logic                  readySelf,
    input  logic                  clearErr,
    output logic [DATA_WIDTH-1:0] outData,
    output logic                  outCS,
    output logic [1:0]            dataSource,
    output logic [1:0]            outputSelect,
    output logic                  controllerEn,
    output logic                  busy,
    output logic [2:0]            dropErr
);

    localparam int CW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    logic [DATA_WIDTH-1:0] in_data [3];
    logic [DATA_WIDTH-1:0] slot_data [3];
    logic [2:0]            cs_in;
    logic [2:0]            pending;
    logic [2:0]            release_mask;
    logic [2:0]            drop;
    logic [2:0]            rr_ptr;
    logic [2:0]            grant_oh;
    logic [2:0]            grant_reg;
    logic [DATA_WIDTH-1:0] sel_data;
    logic [1:0]            sel_src;
    dst_e                  sel_dest;
    logic                  sel_ready;
    dst_e                  dest_reg;
    logic                  wait_ready;
    logic [CW-1:0]         gap_cnt;
    state_e                state;
    state_e                state_next;
    logic                  take_grant;

    assign in_data[IDX_LEFT]  = shiftInLeftData;
    assign in_data[IDX_RIGHT] = shiftInRightData;
    assign in_data[IDX_SELF]  = shiftInData;
    assign cs_in = {shiftInCS, shiftInRightCS, shiftInLeftCS};

    // A slot frees on the edge that leaves SEND; a strobe on a still-busy slot is lost
    assign release_mask = (state == ST_SEND) ? grant_reg : 3'b000;
    assign drop         = cs_in & pending & ~release_mask;
    assign take_grant   = (state == ST_IDLE) && (pending != 3'b000);

    rr_arbiter3 u_rr (
        .req   (pending),
        .ptr   (rr_ptr),
        .grant (grant_oh)
    );

    // Select the granted word and decode its destination and readiness
    always_comb begin
        sel_data = slot_data[IDX_LEFT];
        sel_src  = SRC_NONE;
        if (grant_oh[IDX_LEFT]) begin
            sel_data = slot_data[IDX_LEFT];
            sel_src  = SRC_LEFT;
        end else if (grant_oh[IDX_RIGHT]) begin
            sel_data = slot_data[IDX_RIGHT];
            sel_src  = SRC_RIGHT;
        end else if (grant_oh[IDX_SELF]) begin
            sel_data = slot_data[IDX_SELF];
            sel_src  = SRC_SELF;
        end
        sel_dest = dst_e'(sel_data[DATA_WIDTH-1 -: DEST_W]);
        case (sel_dest)
            DST_LEFT:  sel_ready = readyLeft;
            DST_RIGHT: sel_ready = readyRight;
            DST_SELF:  sel_ready = readySelf;
            default:   sel_ready = 1'b1;
        endcase
        case (dest_reg)
            DST_LEFT:  wait_ready = readyLeft;
            DST_RIGHT: wait_ready = readyRight;
            DST_SELF:  wait_ready = readySelf;
            default:   wait_ready = 1'b1;
        endcase
    end

    // Holding slots, pending bits and sticky drop flags
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            for (int i = 0; i < 3; i++) slot_data[i] <= '0;
            pending <= 3'b000;
            dropErr <= 3'b000;
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (cs_in[i] && !drop[i]) begin
                    slot_data[i] <= in_data[i];
                    pending[i]   <= 1'b1;
                end else if (release_mask[i]) begin
                    pending[i]   <= 1'b0;
                end
            end
            dropErr <= (dropErr & {3{~clearErr}}) | drop;
        end
    end

    // Next-state logic for the grant/send/gap sequence
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (take_grant) state_next = sel_ready ? ST_SEND : ST_WAIT;
            ST_WAIT: if (wait_ready) state_next = ST_SEND;
            ST_SEND: state_next = (GAP_CYCLES > 0) ? ST_GAP : ST_IDLE;
            ST_GAP:  if (gap_cnt == '0) state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // State register plus the latched grant, mux controls and gap counter
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state        <= ST_IDLE;
            rr_ptr       <= 3'b100;
            grant_reg    <= 3'b000;
            dest_reg     <= DST_CTRL;
            dataSource   <= SRC_NONE;
            outputSelect <= DST_CTRL;
            outData      <= '0;
            gap_cnt      <= '0;
        end else begin
            state <= state_next;
            if (take_grant) begin
                grant_reg    <= grant_oh;
                rr_ptr       <= grant_oh;
                dest_reg     <= sel_dest;
                dataSource   <= sel_src;
                outputSelect <= sel_dest;
                outData      <= sel_data;
            end else if (state == ST_SEND) begin
                grant_reg    <= 3'b000;
                dataSource   <= SRC_NONE;
                outputSelect <= DST_CTRL;
                gap_cnt      <= CW'(GAP_CYCLES - 1);
            end else if (state == ST_GAP && gap_cnt != '0) begin
                gap_cnt <= gap_cnt - 1'b1;
            end
        end
    end

    assign outCS        = (state == ST_SEND) && (dest_reg != DST_CTRL);
    assign controllerEn = (state == ST_SEND) && (dest_reg == DST_CTRL);
    assign busy         = (state != ST_IDLE);

endmodule

// File: doc/node_port_arbiter.md
Name: node_port_arbiter

Overview:
Round-robin arbiter and transfer sequencer for a one-dimensional interconnect node. It captures words arriving from the left neighbour, the right neighbour and the local (self) port into one-deep per-source holding slots. It grants one source at a time and decodes the destination field of the granted word. It then drives the node's dataSource/outputSelect mux controls, a single outgoing data/CS pulse, and the controller-enable path, honouring per-destination ready back-pressure.

Parameters:
DATA_WIDTH, 32, word width of all data paths
GAP_CYCLES, 2, idle cycles inserted after each transfer before the next grant (0 allowed)

Ports:
clk  input  1  single clock, rising edge
resetN  input  1  asynchronous active-low reset
shiftInLeftData  input  DATA_WIDTH  word from left neighbour
shiftInLeftCS  input  1  one-cycle strobe: left word valid
shiftInRightData  input  DATA_WIDTH  word from right neighbour
shiftInRightCS  input  1  one-cycle strobe: right word valid
shiftInData  input  DATA_WIDTH  word from local port
shiftInCS  input  1  one-cycle strobe: local word valid
readyLeft  input  1  left output can accept a word
readyRight  input  1  right output can accept a word
readySelf  input  1  local output can accept a word
clearErr  input  1  clears dropErr (synchronous)
outData  output  DATA_WIDTH  granted word
outCS  output  1  one-cycle strobe: outData valid at outputSelect target
dataSource  output  2  00 none, 01 left, 10 right, 11 self
outputSelect  output  2  00 controller, 01 left, 10 right, 11 self
controllerEn  output  1  one-cycle strobe: outData is a controller instruction
busy  output  1  high in any state other than IDLE
dropErr  output  3  sticky overflow flags {self,right,left}

Behaviour:
- Reset (async, resetN=0): all outputs 0, all slots empty, state IDLE, RR pointer = self (first priority is left, then right, then self).
- Capture: a CS high at edge k loads the matching slot and sets its pending bit. If the slot is already pending and not being released at edge k, the word is dropped and its dropErr bit is set. Release and capture in the same edge: the release happens first and the new word is accepted.
- Destination = data[DATA_WIDTH-1:DATA_WIDTH-2]: 00 controller, 01 left, 10 right, 11 self. Controller destination is always ready.
- Arbitration: combinational round-robin over pending bits, starting from the source after the RR pointer. It is evaluated only in IDLE. The pointer is updated to the granted source when the grant is taken.
- FSM states: IDLE, WAIT, SEND, GAP.
  - IDLE: if any source is pending, register the grant. This latches dataSource, outputSelect and outData. Go to SEND if the destination's ready is high at that edge, otherwise go to WAIT.
  - WAIT: hold grant and outputs. Go to SEND at the first edge where the destination's ready is high. No re-arbitration occurs while waiting.
  - SEND: exactly one cycle. outCS=1, or controllerEn=1 instead when the destination is 00. Both are never high together. The granted pending bit is cleared at the edge leaving SEND. Next state is GAP if GAP_CYCLES>0, else IDLE.
  - GAP: counter runs GAP_CYCLES cycles, then IDLE. On entry to GAP, dataSource and outputSelect return to 00. outData holds its last value.
- Latency: CS at edge k with ready high gives grant at edge k+1 and outCS high from k+1 to k+2. Minimum spacing between strobes is GAP_CYCLES+2 cycles.
- dropErr bits are sticky. clearErr clears them at the next edge. A drop in the same cycle as clearErr wins, so the bit stays set.
- Reset mid-transfer: the transfer is aborted immediately and the pending word is lost.

Decomposition:
- Shared package node_pkg holds:
  - source codes SRC_NONE/LEFT/RIGHT/SELF
  - destination codes DST_CTRL/LEFT/RIGHT/SELF
  - FSM state encoding
  - DEST field position
- One sub-module, rr_arbiter3: 3-bit request and pointer in, one-hot grant out, purely combinational.
- Slots, FSM and counter live in the top module.

Test Plan:
- Right CS with 32'hC400_0000, readySelf=1 -> dataSource=10, outputSelect=11, outCS high exactly one cycle, 2 edges after CS, outData=32'hC400_0000.
- Left 32'h4000_0049 and self 32'h8000_0000 strobed in the same cycle, all ready, after reset -> left served first (outputSelect=01), self second, GAP_CYCLES+2 cycles later (outputSelect=10).
- Self CS with 32'h0000_0049 -> controllerEn one cycle, outCS stays 0, outputSelect=00.
- Right word to left (32'h4000_0000) with readyLeft=0 for 5 cycles -> WAIT held, busy=1, no strobe; readyLeft rises -> outCS on the following cycle.
- Two left CS 3 cycles apart while the first is stalled in WAIT -> second dropped, dropErr=3'b001; clearErr pulse -> 3'b000.
- resetN low during WAIT -> all outputs 0 asynchronously; after release no strobe appears for the aborted word.
